// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
package serial_adder_pkg;

   // Default operand/result width.
   localparam int DEFAULT_WIDTH = 8;

   // Controller state encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/sum_comp.sv
// One-bit full adder cell: s = x ^ y ^ z, c = majority(x, y, z).
module sum_comp (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first, carry held in
// a flip-flop between bits. Result and flags hold until the next result lands.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic             w_accept;
   logic             w_last;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;

   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_overflow;

   logic             w_s;
   logic             w_c;

   // Single full-adder cell, fed from the low end of the shift registers.
   sum_comp u_fa (
      .x (r_a_sh[0]),
      .y (r_b_sh[0]),
      .z (r_carry),
      .s (w_s),
      .c (w_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; start is only honoured when not busy (IDLE or DONE).
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_SHIFT;
               w_accept     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == LAST_BIT) begin
               w_state_next = ST_DONE;
               w_last       = 1'b1;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_state_next = ST_SHIFT;
               w_accept     = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, bit-serial shifting and result/flag latching.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_res_sh   <= '0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            // Subtraction is A + ~B + 1; the +1 rides in on the carry.
            r_a_sh   <= a;
            r_b_sh   <= sub ? ~b : b;
            r_carry  <= sub ? 1'b1 : cin;
            r_cnt    <= '0;
            r_res_sh <= '0;
            r_busy   <= 1'b1;
         end else if (r_state == ST_SHIFT) begin
            r_res_sh <= {w_s, r_res_sh[WIDTH-1:1]};
            r_carry  <= w_c;
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
               // r_carry is the carry into the MSB on this edge.
               r_sum      <= {w_s, r_res_sh[WIDTH-1:1]};
               r_cout     <= w_c;
               r_overflow <= r_carry ^ w_c;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
            end
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int n_cmp;
   int n_bad;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: whole-word two's-complement arithmetic.
   function automatic logic [W+1:0] ref_model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                              input logic icin, input logic isub);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         ov;
      bb   = isub ? ~ib : ib;
      full = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, (isub ? 1'b1 : icin)};
      ov   = (ia[W-1] == bb[W-1]) && (full[W-1] != ia[W-1]);
      return {ov, full[W], full[W-1:0]};
   endfunction

   // Launches one operation from the current cycle and waits for done.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                        input logic isub, input bit noisy, output int lat, output int bcyc,
                        output bit hold_ok, output bit timeout);
      logic [W-1:0] prev;
      prev = sum;
      a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bcyc = 0; hold_ok = 1'b1; timeout = 1'b0;
      if (noisy) begin
         start = 1'b1; a = 8'h01; b = 8'h01;
      end
      for (int k = 0; k < 40; k++) begin
         if (done) break;
         if (busy) bcyc++;
         if (sum !== prev) hold_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (noisy) begin
            start = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
         end
      end
      start = 1'b0;
      if (!done) timeout = 1'b1;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, sum, cout, overflow} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                  busy, done, sum, cout, overflow);
      end
      rst_n = 1'b1;
      idle_cycle();
      $display("test_reset: outputs after reset checked");
   endtask

   task automatic check_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic icin, input logic isub, input bit noisy);
      int lat, bcyc; bit hold_ok, timeout;
      logic [W+1:0] exp;
      exp = ref_model(ia, ib, icin, isub);
      do_op(ia, ib, icin, isub, noisy, lat, bcyc, hold_ok, timeout);
      n_cmp++;
      if (timeout) begin
         n_bad++;
         $display("FAIL %s_timeout: no done within 40 cycles", name);
      end
      n_cmp++;
      if ({overflow, cout, sum} !== exp) begin
         n_bad++;
         $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  name, sum, cout, overflow, exp[W-1:0], exp[W], exp[W+1]);
      end
      n_cmp++;
      if (lat != W || bcyc != W || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_timing: got latency=%0d busy_cycles=%0d busy_at_done=%b, want %0d/%0d/0",
                  name, lat, bcyc, busy, W, W);
      end
      n_cmp++;
      if (!hold_ok) begin
         n_bad++;
         $display("FAIL %s_hold: got sum changing while busy, want previous result held", name);
      end
      $display("op %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               name, ia, ib, icin, isub, sum, cout, overflow, lat);
   endtask

   task automatic check_done_drops(input string name);
      idle_cycle();
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done_width: got done=%b one cycle later, want 0", name, done);
      end
   endtask

   task automatic test_add();
      check_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
      check_done_drops("add_5a_3c");
      check_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      check_done_drops("add_ff_01");
      check_op("add_ff_01_cin", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
      check_done_drops("add_ff_01_cin");
   endtask

   task automatic test_sub();
      check_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
      check_done_drops("sub_10_20");
      check_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
      check_done_drops("sub_80_01");
   endtask

   task automatic test_busy_ignore();
      int extra;
      check_op("busy_noise", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
      extra = 0;
      for (int k = 0; k < 15; k++) begin
         idle_cycle();
         if (done || busy) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL busy_noise_single_done: got %0d cycles of extra busy/done, want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      idle_cycle();
      check_op("b2b_first", 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
      check_op("b2b_second", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
      check_done_drops("b2b_second");
   endtask

   task automatic test_reset_mid_op();
      int extra;
      a = 8'h77; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_cmp++;
      if ({busy, done, sum, cout, overflow} !== '0) begin
         n_bad++;
         $display("FAIL midreset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                  busy, done, sum, cout, overflow);
      end
      extra = 0;
      for (int k = 0; k < 15; k++) begin
         idle_cycle();
         if (done || busy) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL midreset_no_done: got %0d cycles with busy/done, want 0", extra);
      end
      $display("test_reset_mid_op: reset at cnt=4 checked");
      check_op("after_reset", 8'hC3, 8'h5E, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic rc, rs;
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         rc = 1'($urandom); rs = 1'($urandom);
         if (i % 3 == 0) idle_cycle();
         check_op($sformatf("rand%0d", i), ra, rb, rc, rs, 1'($urandom_range(0, 3) == 0));
      end
      check_done_drops("rand_last");
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_add();
      test_sub();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
